// File: rtl/mau_pkg.sv
// Shared types and helpers for the memory access unit: size encodings, FSM states,
// byte-lane mask generation and alignment check.
package mau_pkg;

    localparam int unsigned DW_BITS = 64;
    localparam int unsigned LANES   = DW_BITS / 8;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    // Byte lanes touched by an access of the given size at lane offset off.
    function automatic logic [LANES-1:0] size_mask(input logic [1:0] size, input logic [2:0] off);
        logic [LANES-1:0] base;
        case (size)
            SZ_B:    base = 8'h01;
            SZ_H:    base = 8'h03;
            SZ_W:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << off;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
        logic mis;
        case (size)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = off[0];
            SZ_W:    mis = |off[1:0];
            default: mis = |off;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mau_lane_merge.sv
// Combinational byte-lane datapath: load field extraction with sign/zero extension,
// and read-modify-write lane merge for sub-doubleword stores.
module mau_lane_merge
    import mau_pkg::*;
(
    input  logic [DW_BITS-1:0] rd,
    input  logic [DW_BITS-1:0] wdata,
    input  logic [2:0]         off,
    input  logic [1:0]         size,
    input  logic               sgn,
    output logic [DW_BITS-1:0] load_ext_c,
    output logic [DW_BITS-1:0] merge_c
);

    logic [DW_BITS-1:0] shifted;
    logic [DW_BITS-1:0] wshift;
    logic [LANES-1:0]   mask;

    always_comb begin
        shifted    = rd >> {off, 3'b000};
        wshift     = wdata << {off, 3'b000};
        mask       = size_mask(size, off);
        load_ext_c = shifted;
        merge_c    = rd;

        case (size)
            SZ_B: load_ext_c = sgn ? {{56{shifted[7]}},  shifted[7:0]}  : {56'd0, shifted[7:0]};
            SZ_H: load_ext_c = sgn ? {{48{shifted[15]}}, shifted[15:0]} : {48'd0, shifted[15:0]};
            SZ_W: load_ext_c = sgn ? {{32{shifted[31]}}, shifted[31:0]} : {32'd0, shifted[31:0]};
            default: load_ext_c = shifted;
        endcase

        // Lanes outside the access keep the read-back bytes untouched.
        for (int i = 0; i < int'(LANES); i++) begin
            merge_c[8*i +: 8] = mask[i] ? wshift[8*i +: 8] : rd[8*i +: 8];
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store sequencer onto a doubleword-only data memory.
// Optional access counters are compiled in with MAU_ACCESS_COUNT_EN.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int unsigned AW = 64,
    parameter int unsigned DW = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    input  logic          req_store,
    input  logic [1:0]    req_size,
    input  logic          req_signed,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          busy,
    output logic          done,
    output logic          misalign,
    output logic [DW-1:0] load_data,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
`ifdef MAU_ACCESS_COUNT_EN
    ,
    output logic [31:0]   load_count,
    output logic [31:0]   store_count
`endif
);

    state_t        state_q, state_d;
    logic          store_q, sgn_q;
    logic [1:0]    size_q;
    logic [2:0]    off_q;
    logic [DW-1:0] wdata_q;
    logic          latch;

    logic          busy_d, done_d, misalign_d, mem_we_d;
    logic [AW-1:0] mem_a_d;
    logic [DW-1:0] mem_wd_d, load_data_d;
    logic [DW-1:0] load_ext_c, merge_c;

    mau_lane_merge u_lane_merge (
        .rd         (mem_rd),
        .wdata      (wdata_q),
        .off        (off_q),
        .size       (size_q),
        .sgn        (sgn_q),
        .load_ext_c (load_ext_c),
        .merge_c    (merge_c)
    );

    // Next state and next registered output values.
    always_comb begin
        state_d     = state_q;
        latch       = 1'b0;
        busy_d      = busy;
        done_d      = 1'b0;
        misalign_d  = misalign;
        mem_we_d    = 1'b0;
        mem_a_d     = mem_a;
        mem_wd_d    = mem_wd;
        load_data_d = load_data;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    latch   = 1'b1;
                    busy_d  = 1'b1;
                    mem_a_d = {req_addr[AW-1:3], 3'b000};
                    if (is_misaligned(req_size, req_addr[2:0])) begin
                        state_d    = ST_DONE;
                        done_d     = 1'b1;
                        misalign_d = 1'b1;
                    end else if (req_store && (req_size == SZ_D)) begin
                        state_d    = ST_WRITE;
                        mem_we_d   = 1'b1;
                        mem_wd_d   = req_wdata;
                        misalign_d = 1'b0;
                    end else begin
                        state_d    = ST_READ;
                        misalign_d = 1'b0;
                    end
                end
            end
            ST_READ: begin
                if (store_q) begin
                    state_d  = ST_WRITE;
                    mem_we_d = 1'b1;
                    mem_wd_d = merge_c;
                end else begin
                    state_d     = ST_DONE;
                    done_d      = 1'b1;
                    load_data_d = load_ext_c;
                end
            end
            ST_WRITE: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
            ST_DONE: begin
                state_d    = ST_IDLE;
                busy_d     = 1'b0;
                misalign_d = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            misalign  <= 1'b0;
            mem_we    <= 1'b0;
            mem_a     <= '0;
            mem_wd    <= '0;
            load_data <= '0;
        end else begin
            state_q   <= state_d;
            busy      <= busy_d;
            done      <= done_d;
            misalign  <= misalign_d;
            mem_we    <= mem_we_d;
            mem_a     <= mem_a_d;
            mem_wd    <= mem_wd_d;
            load_data <= load_data_d;
        end
    end

    // Latched request; the requester may change its fields after accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            store_q <= 1'b0;
            sgn_q   <= 1'b0;
            size_q  <= SZ_B;
            off_q   <= 3'd0;
            wdata_q <= '0;
        end else if (latch) begin
            store_q <= req_store;
            sgn_q   <= req_signed;
            size_q  <= req_size;
            off_q   <= req_addr[2:0];
            wdata_q <= req_wdata;
        end
    end

`ifdef MAU_ACCESS_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_count  <= 32'd0;
            store_count <= 32'd0;
        end else if ((state_q == ST_DONE) && !misalign) begin
            if (store_q) store_count <= store_count + 32'd1;
            else         load_count  <= load_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a small doubleword memory model.
// Counter checks are included when MAU_ACCESS_COUNT_EN is defined.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_store, req_signed;
    logic [1:0]  req_size;
    logic [63:0] req_addr, req_wdata;
    logic        busy, done, misalign, mem_we;
    logic [63:0] load_data, mem_a, mem_wd, mem_rd;
`ifdef MAU_ACCESS_COUNT_EN
    logic [31:0] load_count, store_count;
`endif

    mem_access_unit #(.AW(64), .DW(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_store  (req_store),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .busy       (busy),
        .done       (done),
        .misalign   (misalign),
        .load_data  (load_data),
        .mem_we     (mem_we),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
`ifdef MAU_ACCESS_COUNT_EN
        ,
        .load_count (load_count),
        .store_count(store_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: 16 doublewords, preloaded once.
    logic [63:0] mem [0:15];
    logic        mem_init_done = 1'b0;
    assign mem_rd = mem[mem_a[6:3]];
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 16; i++) mem[i] <= 64'd0;
            mem[8] <= 64'h8877665544332211;
            mem_init_done <= 1'b1;
        end else if (mem_we) begin
            mem[mem_a[6:3]] <= mem_wd;
        end
    end

    typedef struct {
        logic        mis;
        logic [63:0] ld;
        int          acc;
        int          lat;
    } exp_t;
    typedef struct {
        logic [63:0] a;
        logic [63:0] d;
        int          wcyc;
    } wr_t;

    exp_t exp_q[$];
    wr_t  wr_q[$];
    int   vecs = 0;
    int   miss = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        vecs++;
        if (act !== expv) begin
            miss++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Completion monitor.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("misalign", 64'(misalign), 64'(e.mis));
                check("load_data", load_data, e.ld);
                check("done_latency", 64'(cyc - e.acc + 1), 64'(e.lat));
                check("busy_with_done", 64'(busy), 64'd1);
            end
        end
    end

    // Memory write monitor.
    always @(negedge clk) begin
        if (!reset && mem_we) begin
            if (wr_q.size() == 0) begin
                check("unexpected_mem_we", 64'd1, 64'd0);
            end else begin
                wr_t w;
                w = wr_q.pop_front();
                check("mem_a", mem_a, w.a);
                check("mem_wd", mem_wd, w.d);
                check("mem_we_cycle", 64'(cyc), 64'(w.wcyc));
            end
        end
    end

    task automatic do_req(input logic st, input logic [1:0] sz, input logic sg,
                          input logic [63:0] addr, input logic [63:0] wd,
                          input logic exp_mis, input logic [63:0] exp_ld, input int exp_lat,
                          input logic exp_wr, input logic [63:0] exp_wa,
                          input logic [63:0] exp_wd, input int wr_off);
        exp_t e;
        wr_t  w;
        @(negedge clk);
        req_valid = 1'b1; req_store = st; req_size = sz; req_signed = sg;
        req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_store  = ~st;
        req_size   = 2'($urandom);
        req_signed = ~sg;
        req_addr   = {$urandom, $urandom};
        req_wdata  = {$urandom, $urandom};
        e.mis = exp_mis; e.ld = exp_ld; e.acc = cyc; e.lat = exp_lat;
        exp_q.push_back(e);
        if (exp_wr) begin
            w.a = exp_wa; w.d = exp_wd; w.wcyc = cyc + wr_off;
            wr_q.push_back(w);
        end
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        if (busy) check("busy_timeout", 64'd1, 64'd0);
        @(negedge clk);
        check("done_seen", 64'(exp_q.size()), 64'd0);
        check("write_seen", 64'(wr_q.size()), 64'd0);
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = 64'd0; req_wdata = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_misalign", 64'(misalign), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_load_data", load_data, 64'd0);
        check("rst_mem_a", mem_a, 64'd0);
        check("rst_mem_wd", mem_wd, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // st  sz     sg    addr   wdata                 mis   exp load                lat wr  wa     wd                     off
        do_req(0, 2'b00, 1, 64'h47, 64'd0,               1'b0, 64'hFFFFFFFFFFFFFF88, 2, 0, 64'h0,  64'h0,                  0);
        do_req(0, 2'b00, 0, 64'h47, 64'd0,               1'b0, 64'h0000000000000088, 2, 0, 64'h0,  64'h0,                  0);
        do_req(0, 2'b10, 1, 64'h44, 64'd0,               1'b0, 64'hFFFFFFFF88776655, 2, 0, 64'h0,  64'h0,                  0);
        do_req(0, 2'b01, 0, 64'h42, 64'd0,               1'b0, 64'h0000000000004433, 2, 0, 64'h0,  64'h0,                  0);
        do_req(1, 2'b00, 0, 64'h41, 64'h123456789ABCDEAB, 1'b0, 64'h0000000000004433, 3, 1, 64'h40, 64'h887766554433AB11, 1);
        do_req(1, 2'b11, 0, 64'h48, 64'h0123456789ABCDEF, 1'b0, 64'h0000000000004433, 2, 1, 64'h48, 64'h0123456789ABCDEF, 0);
        do_req(0, 2'b01, 0, 64'h43, 64'd0,               1'b1, 64'h0000000000004433, 1, 0, 64'h0,  64'h0,                  0);
        do_req(0, 2'b11, 1, 64'h48, 64'd0,               1'b0, 64'h0123456789ABCDEF, 2, 0, 64'h0,  64'h0,                  0);
        do_req(1, 2'b01, 1, 64'h4A, 64'hCAFE00000000BEEF, 1'b0, 64'h0123456789ABCDEF, 3, 1, 64'h48, 64'h01234567BEEFCDEF, 1);
        do_req(0, 2'b10, 0, 64'h40, 64'd0,               1'b0, 64'h000000004433AB11, 2, 0, 64'h0,  64'h0,                  0);
        do_req(1, 2'b10, 0, 64'h42, 64'hDEADBEEF,        1'b1, 64'h000000004433AB11, 1, 0, 64'h0,  64'h0,                  0);
        check("mem_after_sh", mem[9], 64'h01234567BEEFCDEF);
`ifdef MAU_ACCESS_COUNT_EN
        check("load_count", 64'(load_count), 64'd6);
        check("store_count", 64'(store_count), 64'd3);
`endif

        // Reset while a byte store sits in READ: no write may reach memory.
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 64'h40; req_wdata = 64'h55;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("pre_reset_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_mem_we", 64'(mem_we), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_load_data", load_data, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("post_rst_busy", 64'(busy), 64'd0);
        check("mem_unchanged", mem[8], 64'h887766554433AB11);
`ifdef MAU_ACCESS_COUNT_EN
        check("rst_load_count", 64'(load_count), 64'd0);
        check("rst_store_count", 64'(store_count), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
